multicycle_control: RTL

- FSM-based control unit for the multi-cycle LEGv8 datapath; the next generation of the single-cycle decoder.
- Decodes the 11-bit opcode latched in the IR and sequences FETCH/DECODE/EXEC/MEM/WB.
- Issues per-state datapath enables and handshakes with variable-latency instruction and data memories.
- Adds ADDI/SUBI/MOVZ support, memory wait states, timeout detection and sticky fault reporting.

---
 rtl/multicycle_pkg.sv | 71 +++++++
 rtl/multicycle_control_if.sv | 46 ++++
 rtl/control_decode.sv | 55 +++++
 rtl/multicycle_control.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control unit:
// FSM states, instruction classes, opcode match patterns, ALU/sign-extend/fault codes.
package multicycle_pkg;

   localparam int OPCODE_W_C = 11;
   localparam int ALUOP_W_C  = 4;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_FAULT  = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CL_ADD  = 4'd0,
      CL_SUB  = 4'd1,
      CL_AND  = 4'd2,
      CL_ORR  = 4'd3,
      CL_ADDI = 4'd4,
      CL_SUBI = 4'd5,
      CL_MOVZ = 4'd6,
      CL_LDUR = 4'd7,
      CL_STUR = 4'd8,
      CL_CBZ  = 4'd9,
      CL_B    = 4'd10,
      CL_ILL  = 4'd11
   } iclass_e;

   // A mask bit of 0 marks an operand bit that sits inside the opcode field.
   typedef struct packed {
      logic [10:0] val;
      logic [10:0] mask;
   } oppat_t;

   localparam oppat_t PAT_LDUR = '{val: 11'b11111000010, mask: 11'b11111111111};
   localparam oppat_t PAT_STUR = '{val: 11'b11111000000, mask: 11'b11111111111};
   localparam oppat_t PAT_ADD  = '{val: 11'b10001011000, mask: 11'b11111111111};
   localparam oppat_t PAT_SUB  = '{val: 11'b11001011000, mask: 11'b11111111111};
   localparam oppat_t PAT_AND  = '{val: 11'b10001010000, mask: 11'b11111111111};
   localparam oppat_t PAT_ORR  = '{val: 11'b10101010000, mask: 11'b11111111111};
   localparam oppat_t PAT_ADDI = '{val: 11'b10010001000, mask: 11'b11111111110};
   localparam oppat_t PAT_SUBI = '{val: 11'b11010001000, mask: 11'b11111111110};
   localparam oppat_t PAT_MOVZ = '{val: 11'b11010010100, mask: 11'b11111111100};
   localparam oppat_t PAT_CBZ  = '{val: 11'b10110100000, mask: 11'b11111111000};
   localparam oppat_t PAT_B    = '{val: 11'b00010100000, mask: 11'b11111100000};

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   localparam logic [2:0] SIGN_B    = 3'b000;
   localparam logic [2:0] SIGN_CB   = 3'b001;
   localparam logic [2:0] SIGN_I    = 3'b010;
   localparam logic [2:0] SIGN_D    = 3'b011;
   localparam logic [2:0] SIGN_MOVZ = 3'b100;

   localparam logic [1:0] FC_NONE = 2'b00;
   localparam logic [1:0] FC_ILL  = 2'b01;
   localparam logic [1:0] FC_IMEM = 2'b10;
   localparam logic [1:0] FC_DMEM = 2'b11;

   function automatic logic op_match(input logic [10:0] op, input oppat_t pat);
      return ((op ^ pat.val) & pat.mask) == 11'b00000000000;
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath boundary of the multi-cycle core: the control unit is the
// master (drives selects and memory requests), the datapath/memories the slave.
interface multicycle_control_if
   import multicycle_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_C,
   parameter int ALUOP_W  = ALUOP_W_C
) ();

   logic [OPCODE_W-1:0] opcode;
   logic                zero;
   logic                imem_ready;
   logic                dmem_ready;

   logic                imem_req;
   logic                ir_write;
   logic                pc_write;
   logic                pc_src;
   logic                reg2loc;
   logic                alusrc;
   logic                mem2reg;
   logic                regwrite;
   logic                memread;
   logic                memwrite;
   logic [ALUOP_W-1:0]  aluop;
   logic [2:0]          signop;
   logic [1:0]          movz_shift;
   logic                instr_done;
   logic                fault;
   logic [1:0]          fault_code;

   modport master (
      input  opcode, zero, imem_ready, dmem_ready,
      output imem_req, ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg,
             regwrite, memread, memwrite, aluop, signop, movz_shift,
             instr_done, fault, fault_code
   );

   modport slave (
      output opcode, zero, imem_ready, dmem_ready,
      input  imem_req, ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg,
             regwrite, memread, memwrite, aluop, signop, movz_shift,
             instr_done, fault, fault_code
   );

endinterface

// File: rtl/control_decode.sv
// Combinational opcode classifier: maps the latched IR opcode to an instruction
// class plus its ALU operation and immediate sign-extend mode.
module control_decode
   import multicycle_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_C,
   parameter int ALUOP_W  = ALUOP_W_C
) (
   input  logic [OPCODE_W-1:0] opcode_i,
   output iclass_e             iclass_o,
   output logic [ALUOP_W-1:0]  aluop_o,
   output logic [2:0]          signop_o,
   output logic                valid_o
);

   // Priority match: earlier patterns win if encodings ever overlap.
   always_comb begin
      iclass_o = CL_ILL;
      if      (op_match(opcode_i, PAT_LDUR)) iclass_o = CL_LDUR;
      else if (op_match(opcode_i, PAT_STUR)) iclass_o = CL_STUR;
      else if (op_match(opcode_i, PAT_ADD))  iclass_o = CL_ADD;
      else if (op_match(opcode_i, PAT_SUB))  iclass_o = CL_SUB;
      else if (op_match(opcode_i, PAT_AND))  iclass_o = CL_AND;
      else if (op_match(opcode_i, PAT_ORR))  iclass_o = CL_ORR;
      else if (op_match(opcode_i, PAT_ADDI)) iclass_o = CL_ADDI;
      else if (op_match(opcode_i, PAT_SUBI)) iclass_o = CL_SUBI;
      else if (op_match(opcode_i, PAT_MOVZ)) iclass_o = CL_MOVZ;
      else if (op_match(opcode_i, PAT_CBZ))  iclass_o = CL_CBZ;
      else if (op_match(opcode_i, PAT_B))    iclass_o = CL_B;
      else                                   iclass_o = CL_ILL;
   end

   // Per-class ALU operation and sign-extend mode.
   always_comb begin
      aluop_o  = ALU_AND;
      signop_o = SIGN_B;
      case (iclass_o)
         CL_ADD:  aluop_o = ALU_ADD;
         CL_SUB:  aluop_o = ALU_SUB;
         CL_AND:  aluop_o = ALU_AND;
         CL_ORR:  aluop_o = ALU_OR;
         CL_ADDI: begin aluop_o = ALU_ADD;   signop_o = SIGN_I;    end
         CL_SUBI: begin aluop_o = ALU_SUB;   signop_o = SIGN_I;    end
         CL_MOVZ: begin aluop_o = ALU_PASSB; signop_o = SIGN_MOVZ; end
         CL_LDUR: begin aluop_o = ALU_ADD;   signop_o = SIGN_D;    end
         CL_STUR: begin aluop_o = ALU_ADD;   signop_o = SIGN_D;    end
         CL_CBZ:  begin aluop_o = ALU_PASSB; signop_o = SIGN_CB;   end
         CL_B:    begin aluop_o = ALU_AND;   signop_o = SIGN_B;    end
         default: begin aluop_o = ALU_AND;   signop_o = SIGN_B;    end
      endcase
   end

   assign valid_o = (iclass_o != CL_ILL);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, waits on
// variable-latency memories with a saturating timeout counter, and latches a sticky fault.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_C,
   parameter int ALUOP_W  = ALUOP_W_C,
   parameter int TIMEOUT  = 16
) (
   input  logic                 CLK,
   input  logic                 Reset_L,
   multicycle_control_if.master bus
);

   localparam int              CNT_W    = (TIMEOUT > 32'sd0) ? $clog2(TIMEOUT + 32'sd1) : 1;
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
   localparam bit              TO_EN    = (TIMEOUT != 32'sd0);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               fault_q, fault_d;
   logic [1:0]         code_q, code_d;

   logic [OPCODE_W-1:0] opcode_s;
   iclass_e             iclass_s;
   logic [ALUOP_W-1:0]  dec_aluop_s;
   logic [2:0]          dec_signop_s;
   logic                dec_valid_s;
   logic                timeout_hit_s;
   logic [CNT_W-1:0]    cnt_inc_s;

   logic imem_req_s, ir_write_s, pc_write_s, pc_src_s, reg2loc_s, alusrc_s;
   logic mem2reg_s, regwrite_s, memread_s, memwrite_s, instr_done_s;
   logic [ALUOP_W-1:0] aluop_s;
   logic [2:0]         signop_s;
   logic [1:0]         movz_shift_s;

   assign opcode_s = bus.opcode;

   control_decode #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) u_decode (
      .opcode_i (opcode_s),
      .iclass_o (iclass_s),
      .aluop_o  (dec_aluop_s),
      .signop_o (dec_signop_s),
      .valid_o  (dec_valid_s)
   );

   // Ready arriving on the TIMEOUT cycle is checked first, so it wins over the fault.
   assign timeout_hit_s = TO_EN && (cnt_q == TO_LIMIT);
   assign cnt_inc_s     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   // State, wait counter and sticky fault registers.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q <= ST_FETCH;
         cnt_q   <= '0;
         fault_q <= 1'b0;
         code_q  <= FC_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
         code_q  <= code_d;
      end
   end

   // Next-state, wait counter and fault capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fault_d = fault_q;
      code_d  = code_q;
      case (state_q)
         ST_FETCH: begin
            if (bus.imem_ready) begin
               state_d = ST_DECODE;
            end else if (timeout_hit_s) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               code_d  = FC_IMEM;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         ST_DECODE: begin
            if (dec_valid_s) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               code_d  = FC_ILL;
            end
         end
         ST_EXEC: begin
            cnt_d = '0;
            case (iclass_s)
               CL_LDUR, CL_STUR: state_d = ST_MEM;
               CL_CBZ, CL_B:     state_d = ST_FETCH;
               default:          state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (bus.dmem_ready) begin
               cnt_d   = '0;
               state_d = (iclass_s == CL_STUR) ? ST_FETCH : ST_WB;
            end else if (timeout_hit_s) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               code_d  = FC_DMEM;
            end else begin
               cnt_d = cnt_inc_s;
            end
         end
         ST_WB: begin
            cnt_d   = '0;
            state_d = ST_FETCH;
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
         end
      endcase
   end

   // Per-state datapath controls; everything held low while reset is asserted.
   always_comb begin
      imem_req_s   = 1'b0;
      ir_write_s   = 1'b0;
      pc_write_s   = 1'b0;
      pc_src_s     = 1'b0;
      reg2loc_s    = 1'b0;
      alusrc_s     = 1'b0;
      mem2reg_s    = 1'b0;
      regwrite_s   = 1'b0;
      memread_s    = 1'b0;
      memwrite_s   = 1'b0;
      instr_done_s = 1'b0;
      aluop_s      = '0;
      signop_s     = 3'b000;
      movz_shift_s = 2'b00;
      if (Reset_L) begin
         case (state_q)
            ST_FETCH: begin
               imem_req_s = 1'b1;
               ir_write_s = bus.imem_ready;
            end
            ST_EXEC: begin
               aluop_s  = dec_aluop_s;
               signop_s = dec_signop_s;
               case (iclass_s)
                  CL_ADDI, CL_SUBI, CL_LDUR: alusrc_s = 1'b1;
                  CL_MOVZ: begin
                     alusrc_s     = 1'b1;
                     movz_shift_s = opcode_s[1:0];
                  end
                  CL_STUR: begin
                     alusrc_s  = 1'b1;
                     reg2loc_s = 1'b1;
                  end
                  CL_CBZ: begin
                     reg2loc_s    = 1'b1;
                     pc_write_s   = 1'b1;
                     pc_src_s     = bus.zero;
                     instr_done_s = 1'b1;
                  end
                  CL_B: begin
                     pc_write_s   = 1'b1;
                     pc_src_s     = 1'b1;
                     instr_done_s = 1'b1;
                  end
                  default: alusrc_s = 1'b0;
               endcase
            end
            ST_MEM: begin
               memread_s  = (iclass_s == CL_LDUR);
               memwrite_s = (iclass_s == CL_STUR);
               if (bus.dmem_ready && (iclass_s == CL_STUR)) begin
                  pc_write_s   = 1'b1;
                  instr_done_s = 1'b1;
               end else begin
                  pc_write_s   = 1'b0;
               end
            end
            ST_WB: begin
               regwrite_s   = 1'b1;
               mem2reg_s    = (iclass_s == CL_LDUR);
               pc_write_s   = 1'b1;
               instr_done_s = 1'b1;
            end
            default: imem_req_s = 1'b0;
         endcase
      end else begin
         imem_req_s = 1'b0;
      end
   end

   assign bus.imem_req   = imem_req_s;
   assign bus.ir_write   = ir_write_s;
   assign bus.pc_write   = pc_write_s;
   assign bus.pc_src     = pc_src_s;
   assign bus.reg2loc    = reg2loc_s;
   assign bus.alusrc     = alusrc_s;
   assign bus.mem2reg    = mem2reg_s;
   assign bus.regwrite   = regwrite_s;
   assign bus.memread    = memread_s;
   assign bus.memwrite   = memwrite_s;
   assign bus.aluop      = aluop_s;
   assign bus.signop     = signop_s;
   assign bus.movz_shift = movz_shift_s;
   assign bus.instr_done = instr_done_s;
   assign bus.fault      = fault_q;
   assign bus.fault_code = code_q;

endmodule
